// File: rtl/spi_pkg.sv
// Shared definitions for the single-byte SPI master: FSM states and default geometry.
package spi_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Serial clock divider: registered sclk plus one-cycle strobes marking the
// system-clock edge on which sclk rises or falls. Held idle-low while disabled.
module spi_clk_gen #(
  parameter int CLK_DIV = spi_pkg::DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          term_s;

  assign term_s      = (div_q == CW'(CLK_DIV - 1));
  assign rise_tick_o = en_i & term_s & ~sclk_q;
  assign fall_tick_o = en_i & term_s & sclk_q;
  assign sclk_o      = sclk_q;

  // Divider next state; disabling clears the count so every frame starts with a full half-period.
  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (term_s) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + CW'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0, MSB first: frames one byte exchange per start
// request and presents the received byte once the frame has fully completed.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ready_send,
  output logic                  mosi,
  output logic                  sclk,
  output logic                  ss,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_e                state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  mosi_q, mosi_d;
  logic                  ss_q, ss_d;
  logic                  rise_s, fall_s;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q == ST_XFER),
    .sclk_o      (sclk),
    .rise_tick_o (rise_s),
    .fall_tick_o (fall_s)
  );

  // Frame FSM; ss stays high through DONE so back-to-back frames are separated by one IDLE cycle.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    mosi_d  = mosi_q;
    ss_d    = ss_q;
    case (state_q)
      ST_IDLE: begin
        if (ready_send) begin
          tx_d    = data_in;
          rx_d    = '0;
          mosi_d  = data_in[DATA_WIDTH-1];
          ss_d    = 1'b1;
          bit_d   = '0;
          state_d = ST_XFER;
        end else begin
          mosi_d  = 1'b0;
          ss_d    = 1'b0;
        end
      end
      ST_XFER: begin
        if (rise_s) begin
          rx_d = {rx_q[DATA_WIDTH-2:0], miso};
        end else begin
          rx_d = rx_q;
        end
        if (fall_s && (bit_q == BW'(DATA_WIDTH - 1))) begin
          dout_d  = rx_q;
          mosi_d  = 1'b0;
          state_d = ST_DONE;
        end else if (fall_s) begin
          tx_d   = tx_q << 1;
          mosi_d = tx_q[DATA_WIDTH-2];
          bit_d  = bit_q + BW'(1);
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_DONE: begin
        mosi_d  = 1'b0;
        ss_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        mosi_d  = 1'b0;
        ss_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
    end
  end

  assign mosi     = mosi_q;
  assign ss       = ss_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus queues expected (tx, rx) frames, a
// negedge monitor plays the SPI slave and checks every completed frame.
module tb_spi_master;

  localparam int DW = 8;
  localparam int CD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          miso = 1'b0;
  logic          ready_send = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          mosi, sclk, ss;
  logic [DW-1:0] data_out;

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk        (clk),
    .rst        (rst),
    .miso       (miso),
    .data_in    (data_in),
    .ready_send (ready_send),
    .mosi       (mosi),
    .sclk       (sclk),
    .ss         (ss),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
  } frame_t;

  frame_t        exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] last_out = '0;
  bit            expect_gap1 = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  // Monitor / slave model state
  bit            in_frame = 1'b0;
  bit            prev_ss = 1'b0, prev_sclk = 1'b0;
  frame_t        cur;
  logic [DW-1:0] mosi_byte;
  int            pulses, hi_len, lo_len, ss_len, low_len = 0, bit_idx;
  bit            timing_bad, partial_bad;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_frame) begin
        void'(exp_q.pop_front());
        last_out = '0;
      end
      in_frame  = 1'b0;
      miso      = 1'b0;
      prev_ss   = 1'b0;
      prev_sclk = 1'b0;
      low_len   = 0;
    end else begin
      if (ss && !prev_ss) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          cur         = exp_q[0];
          in_frame    = 1'b1;
          mosi_byte   = '0;
          pulses      = 0;
          hi_len      = 0;
          lo_len      = 0;
          ss_len      = 0;
          timing_bad  = 1'b0;
          partial_bad = 1'b0;
          miso        = cur.rx[DW-1];
          bit_idx     = DW - 2;
          if (expect_gap1) begin
            check("b2b_ss_low_cycles", low_len, 1);
            expect_gap1 = 1'b0;
          end
        end
      end
      if (in_frame && ss) begin
        ss_len++;
        if (sclk && !prev_sclk) begin
          mosi_byte = {mosi_byte[DW-2:0], mosi};
          pulses++;
          if (lo_len != CD) timing_bad = 1'b1;
          hi_len = 1;
        end else if (!sclk && prev_sclk) begin
          if (hi_len != CD) timing_bad = 1'b1;
          lo_len = 1;
          if (bit_idx >= 0) begin
            miso = cur.rx[bit_idx];
            bit_idx--;
          end
        end else if (sclk) begin
          hi_len++;
        end else begin
          lo_len++;
        end
        if (pulses < DW && data_out !== last_out) partial_bad = 1'b1;
      end
      if (in_frame && !ss && prev_ss) begin
        in_frame = 1'b0;
        void'(exp_q.pop_front());
        check("mosi_byte", int'(mosi_byte), int'(cur.tx));
        check("data_out", int'(data_out), int'(cur.rx));
        check("sclk_pulses", pulses, DW);
        check("sclk_timing_ok", int'(timing_bad), 0);
        check("ss_high_cycles", ss_len, DW * 2 * CD + 1);
        check("data_out_held_in_frame", int'(partial_bad), 0);
        last_out = cur.rx;
      end
      low_len   = ss ? 0 : low_len + 1;
      prev_ss   = ss;
      prev_sclk = sclk;
    end
  end

  task automatic wait_ss(input logic level, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ss === level) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, int'(ok), 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ss) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_complete_in_time", int'(ok), 1);
  endtask

  task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] rx);
    exp_q.push_back('{tx: tx, rx: rx});
    data_in    = tx;
    ready_send = 1'b1;
    wait_ss(1'b1, "ss_start");
    ready_send = 1'b0;
    data_in    = DW'($urandom);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ss", int'(ss), 0);
    check("rst_sclk", int'(sclk), 0);
    check("rst_mosi", int'(mosi), 0);
    check("rst_data_out", int'(data_out), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_ss", int'(ss), 0);
    check("idle_sclk", int'(sclk), 0);

    run_frame(8'h13, 8'h37);
    run_frame(8'h00, 8'hFF);
    run_frame(8'hFF, 8'h00);

    // Back-to-back frames with ready_send held high
    exp_q.push_back('{tx: 8'hA5, rx: 8'h69});
    exp_q.push_back('{tx: 8'h5A, rx: 8'h96});
    data_in    = 8'hA5;
    ready_send = 1'b1;
    wait_ss(1'b1, "b2b_first_start");
    data_in    = 8'h5A;
    @(negedge clk);
    expect_gap1 = 1'b1;
    wait_ss(1'b0, "b2b_first_end");
    wait_ss(1'b1, "b2b_second_start");
    ready_send = 1'b0;
    wait_idle();

    // Input isolation: wiggle data_in and ready_send mid-frame
    exp_q.push_back('{tx: 8'h3C, rx: 8'hC3});
    data_in    = 8'h3C;
    ready_send = 1'b1;
    wait_ss(1'b1, "iso_start");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ready_send = i[0];
      data_in    = DW'($urandom);
    end
    ready_send = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // Abort after 3 sclk pulses
    exp_q.push_back('{tx: 8'hE7, rx: 8'h81});
    data_in    = 8'hE7;
    ready_send = 1'b1;
    wait_ss(1'b1, "abort_start");
    ready_send = 1'b0;
    begin
      int  falls = 0;
      bit  ps    = 1'b0;
      for (int i = 0; i < 100 && falls < 3; i++) begin
        @(negedge clk);
        if (!sclk && ps) falls++;
        ps = sclk;
      end
      check("abort_reached_3_pulses", falls, 3);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_ss", int'(ss), 0);
    check("abort_sclk", int'(sclk), 0);
    check("abort_mosi", int'(mosi), 0);
    check("abort_data_out", int'(data_out), 0);
    repeat (2) @(negedge clk);
    check("abort_queue_cleared", exp_q.size(), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(8'h81, 8'h7E);

    // Randomized exchanges
    for (int i = 0; i < 6; i++) begin
      run_frame(DW'($urandom), DW'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
